// File: rtl/dnn_result_argmax.sv
// Result stage: snapshots engine class scores, scans them for the argmax, and offers a registered score readout.
// Optional tie output is built when ARGMAX_TIE_FLAG_EN is defined.
module dnn_result_argmax #(
  parameter int NUM_CLASSES = 10,
  parameter int DATA_WIDTH  = 3,
  parameter int IDX_WIDTH   = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  input  logic [NUM_CLASSES*DATA_WIDTH-1:0] in_data,
  input  logic                              clear,
  output logic                              busy,
  output logic                              res_valid,
  output logic [IDX_WIDTH-1:0]              class_idx,
  output logic [DATA_WIDTH-1:0]             class_score,
  input  logic [IDX_WIDTH-1:0]              rd_idx,
  output logic [DATA_WIDTH-1:0]             rd_data
`ifdef ARGMAX_TIE_FLAG_EN
  ,
  output logic                              tie
`endif
);

  // state   | meaning
  // IDLE    | no result, waiting for engine done
  // CAPTURE | scores snapshotted, best seeded with class 0
  // SCAN    | comparing class cnt against best, one per cycle
  // DONE    | result valid and held

  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_SCAN, S_DONE} state_t;

  state_t                        state_q, state_d;
  logic signed [DATA_WIDTH-1:0]  bank_q [NUM_CLASSES];
  logic [IDX_WIDTH-1:0]          cnt_q, cnt_d;
  logic [IDX_WIDTH-1:0]          best_idx_q, best_idx_d;
  logic signed [DATA_WIDTH-1:0]  best_score_q, best_score_d;
  logic [IDX_WIDTH-1:0]          res_idx_q, res_idx_d;
  logic [DATA_WIDTH-1:0]         res_score_q, res_score_d;
  logic [DATA_WIDTH-1:0]         rd_data_q;
  logic signed [DATA_WIDTH-1:0]  cand;
  logic signed [DATA_WIDTH-1:0]  rd_sel;
  logic                          accept;
`ifdef ARGMAX_TIE_FLAG_EN
  logic                          tie_run_q, tie_run_d;
  logic                          tie_q, tie_d;
`endif

  always_comb begin
    cand = bank_q[0];
    rd_sel = bank_q[0];
    for (int k = 0; k < NUM_CLASSES; k++) begin
      if (cnt_q == IDX_WIDTH'(k)) cand = bank_q[k];
      if (rd_idx == IDX_WIDTH'(k)) rd_sel = bank_q[k];
    end
  end

  assign accept = in_valid && !clear && (state_q == S_IDLE || state_q == S_DONE);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    best_idx_d   = best_idx_q;
    best_score_d = best_score_q;
    res_idx_d    = res_idx_q;
    res_score_d  = res_score_q;
`ifdef ARGMAX_TIE_FLAG_EN
    tie_run_d    = tie_run_q;
    tie_d        = tie_q;
`endif
    case (state_q)
      S_CAPTURE: state_d = S_SCAN;
      S_SCAN: begin
        // strictly greater replaces, so ties keep the lower index
        if (cand > best_score_q) begin
          best_idx_d   = cnt_q;
          best_score_d = cand;
`ifdef ARGMAX_TIE_FLAG_EN
          tie_run_d    = 1'b0;
`endif
        end
`ifdef ARGMAX_TIE_FLAG_EN
        else if (cand == best_score_q) begin
          tie_run_d = 1'b1;
        end
`endif
        cnt_d = cnt_q + IDX_WIDTH'(1);
        if (cnt_q == IDX_WIDTH'(NUM_CLASSES - 1)) begin
          state_d     = S_DONE;
          res_idx_d   = best_idx_d;
          res_score_d = best_score_d;
`ifdef ARGMAX_TIE_FLAG_EN
          tie_d       = tie_run_d;
`endif
        end
      end
      default: ;
    endcase
    if (accept) begin
      state_d      = S_CAPTURE;
      cnt_d        = IDX_WIDTH'(1);
      best_idx_d   = '0;
      best_score_d = in_data[DATA_WIDTH-1:0];
`ifdef ARGMAX_TIE_FLAG_EN
      tie_run_d    = 1'b0;
      tie_d        = 1'b0;
`endif
    end
    if (clear) state_d = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      best_idx_q   <= '0;
      best_score_q <= '0;
      res_idx_q    <= '0;
      res_score_q  <= '0;
      rd_data_q    <= '0;
      for (int k = 0; k < NUM_CLASSES; k++) bank_q[k] <= '0;
`ifdef ARGMAX_TIE_FLAG_EN
      tie_run_q    <= 1'b0;
      tie_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      best_idx_q   <= best_idx_d;
      best_score_q <= best_score_d;
      res_idx_q    <= res_idx_d;
      res_score_q  <= res_score_d;
      rd_data_q    <= rd_sel;
      if (accept) begin
        for (int k = 0; k < NUM_CLASSES; k++) bank_q[k] <= in_data[k*DATA_WIDTH +: DATA_WIDTH];
      end
`ifdef ARGMAX_TIE_FLAG_EN
      tie_run_q    <= tie_run_d;
      tie_q        <= tie_d;
`endif
    end
  end

  assign busy        = (state_q == S_CAPTURE) || (state_q == S_SCAN);
  assign res_valid   = (state_q == S_DONE);
  assign class_idx   = res_idx_q;
  assign class_score = res_score_q;
  assign rd_data     = rd_data_q;
`ifdef ARGMAX_TIE_FLAG_EN
  assign tie         = tie_q;
`endif

endmodule

// File: tb/tb_dnn_result_argmax.sv
// Directed bench for dnn_result_argmax at default parameters; tie checks build with ARGMAX_TIE_FLAG_EN.
module tb_dnn_result_argmax;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [29:0] in_data;
  logic        clear;
  logic        busy;
  logic        res_valid;
  logic [3:0]  class_idx;
  logic [2:0]  class_score;
  logic [3:0]  rd_idx;
  logic [2:0]  rd_data;
`ifdef ARGMAX_TIE_FLAG_EN
  logic        tie;
`endif

  int checks = 0;
  int failures = 0;

  int fa[10] = '{-4, -1, 0, 2, -3, 1, 3, -2, 0, -4};
  int fb[10] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
  int fc[10] = '{-4, -3, -3, -3, -3, -3, -3, -3, -3, 3};
  int fd[10] = '{-2, 1, 0, -1, 2, -3, 1, 3, -4, 0};
  int fe[10] = '{-1, 2, -4, -4, -4, 2, -4, -4, -4, -4};

  dnn_result_argmax dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .clear(clear),
    .busy(busy), .res_valid(res_valid), .class_idx(class_idx), .class_score(class_score),
    .rd_idx(rd_idx), .rd_data(rd_data)
`ifdef ARGMAX_TIE_FLAG_EN
    , .tie(tie)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [29:0] pack(input int s[10]);
    logic [29:0] p;
    for (int k = 0; k < 10; k++) p[k*3 +: 3] = 3'(s[k]);
    return p;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int s[10]);
    in_data = pack(s);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_res(output int n);
    n = 0;
    while (res_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b0; clear = 1'b0; in_data = '0; rd_idx = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL reset_res_valid got=%0b exp=0", res_valid); end
    checks++; if (class_idx !== 4'd0) begin failures++; $display("FAIL reset_idx got=%0d exp=0", class_idx); end
    checks++; if (class_score !== 3'd0) begin failures++; $display("FAIL reset_score got=%0d exp=0", class_score); end
    checks++; if (rd_data !== 3'd0) begin failures++; $display("FAIL reset_rd_data got=%0d exp=0", rd_data); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int n;
    send(fa);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy got=%0b exp=1", busy); end
    wait_res(n);
    checks++; if (n != 10) begin failures++; $display("FAIL basic_latency got=%0d exp=10", n); end
    checks++; if (class_idx !== 4'd6) begin failures++; $display("FAIL basic_idx got=%0d exp=6", class_idx); end
    checks++; if (class_score !== 3'd3) begin failures++; $display("FAIL basic_score got=%0d exp=3", class_score); end
`ifdef ARGMAX_TIE_FLAG_EN
    checks++; if (tie !== 1'b0) begin failures++; $display("FAIL basic_tie got=%0b exp=0", tie); end
`endif
    rd_idx = 4'd3;
    tick();
    checks++; if (rd_data !== 3'd2) begin failures++; $display("FAIL basic_rd3 got=%0d exp=2", rd_data); end
    tick();
    checks++; if (res_valid !== 1'b1) begin failures++; $display("FAIL basic_hold got=%0b exp=1", res_valid); end
  endtask

  task automatic test_ties();
    int n;
    send(fb);
    wait_res(n);
    checks++; if (class_idx !== 4'd0) begin failures++; $display("FAIL tie_all_idx got=%0d exp=0", class_idx); end
    checks++; if (class_score !== 3'd1) begin failures++; $display("FAIL tie_all_score got=%0d exp=1", class_score); end
`ifdef ARGMAX_TIE_FLAG_EN
    checks++; if (tie !== 1'b1) begin failures++; $display("FAIL tie_all_flag got=%0b exp=1", tie); end
`endif
    send(fc);
    wait_res(n);
    checks++; if (class_idx !== 4'd9) begin failures++; $display("FAIL tie_max9_idx got=%0d exp=9", class_idx); end
    checks++; if (class_score !== 3'd3) begin failures++; $display("FAIL tie_max9_score got=%0d exp=3", class_score); end
`ifdef ARGMAX_TIE_FLAG_EN
    checks++; if (tie !== 1'b0) begin failures++; $display("FAIL tie_max9_flag got=%0b exp=0", tie); end
`endif
    send(fe);
    wait_res(n);
    checks++; if (class_idx !== 4'd1) begin failures++; $display("FAIL tie_mid_idx got=%0d exp=1", class_idx); end
    checks++; if (class_score !== 3'd2) begin failures++; $display("FAIL tie_mid_score got=%0d exp=2", class_score); end
`ifdef ARGMAX_TIE_FLAG_EN
    checks++; if (tie !== 1'b1) begin failures++; $display("FAIL tie_mid_flag got=%0b exp=1", tie); end
`endif
  endtask

  task automatic test_busy_drop();
    int n;
    send(fa);
    tick();
    tick();
    send(fb);
    wait_res(n);
    checks++; if (n != 7) begin failures++; $display("FAIL drop_latency got=%0d exp=7", n); end
    checks++; if (class_idx !== 4'd6) begin failures++; $display("FAIL drop_idx got=%0d exp=6", class_idx); end
    checks++; if (class_score !== 3'd3) begin failures++; $display("FAIL drop_score got=%0d exp=3", class_score); end
    rd_idx = 4'd0;
    tick();
    checks++; if (rd_data !== 3'b100) begin failures++; $display("FAIL drop_bank0 got=%0d exp=4(-4)", rd_data); end
    send(fb);
    checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL done_accept_rv got=%0b exp=0", res_valid); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL done_accept_busy got=%0b exp=1", busy); end
    wait_res(n);
    checks++; if (n != 10) begin failures++; $display("FAIL done_accept_latency got=%0d exp=10", n); end
    checks++; if (class_idx !== 4'd0 || class_score !== 3'd1) begin failures++; $display("FAIL done_accept_res got=%0d/%0d exp=0/1", class_idx, class_score); end
  endtask

  task automatic test_clear_in_done();
    rd_idx = 4'd2;
    in_data = pack(fa);
    in_valid = 1'b1;
    clear = 1'b1;
    tick();
    in_valid = 1'b0;
    clear = 1'b0;
    checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL clear_rv got=%0b exp=0", res_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL clear_busy got=%0b exp=0", busy); end
    tick();
    checks++; if (rd_data !== 3'd1) begin failures++; $display("FAIL clear_bank got=%0d exp=1", rd_data); end
    repeat (12) tick();
    checks++; if (res_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL clear_idle got=%0b/%0b exp=0/0", res_valid, busy); end
  endtask

  task automatic test_readout_bounds();
    int n;
    send(fd);
    for (int k = 0; k < 10; k++) begin
      rd_idx = 4'(k);
      tick();
      checks++; if (rd_data !== 3'(fd[k])) begin failures++; $display("FAIL sweep_rd%0d got=%0d exp=%0d", k, rd_data, 3'(fd[k])); end
    end
    rd_idx = 4'd12;
    tick();
    checks++; if (rd_data !== 3'b110) begin failures++; $display("FAIL oob12 got=%0d exp=6(-2)", rd_data); end
    rd_idx = 4'd15;
    tick();
    checks++; if (rd_data !== 3'b110) begin failures++; $display("FAIL oob15 got=%0d exp=6(-2)", rd_data); end
    wait_res(n);
    checks++; if (class_idx !== 4'd7 || class_score !== 3'd3) begin failures++; $display("FAIL sweep_res got=%0d/%0d exp=7/3", class_idx, class_score); end
  endtask

  task automatic test_reset_mid_scan();
    rd_idx = 4'd3;
    send(fa);
    repeat (4) tick();
    checks++; if (busy !== 1'b1 || rd_data !== 3'd2) begin failures++; $display("FAIL midscan_pre got=%0b/%0d exp=1/2", busy, rd_data); end
    rst = 1'b0;
    #2;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midscan_busy got=%0b exp=0", busy); end
    checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL midscan_rv got=%0b exp=0", res_valid); end
    checks++; if (class_idx !== 4'd0) begin failures++; $display("FAIL midscan_idx got=%0d exp=0", class_idx); end
    checks++; if (rd_data !== 3'd0) begin failures++; $display("FAIL midscan_rd got=%0d exp=0", rd_data); end
    tick();
    rst = 1'b1;
    repeat (14) tick();
    checks++; if (res_valid !== 1'b0 || rd_data !== 3'd0) begin failures++; $display("FAIL midscan_after got=%0b/%0d exp=0/0", res_valid, rd_data); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ties();
    test_busy_drop();
    test_clear_in_done();
    test_readout_bounds();
    test_reset_mid_scan();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
